// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the ARM instruction-fetch stage.
//
// Contents:
//   fetch_entry_t     - one prefetch-queue slot: instruction word plus its address
//   RESET_PC_DEFAULT  - default fetch address after reset
//   PC_INC            - sequential fetch stride (one 32-bit word)
//   R15_OFFSET        - distance from an instruction's address to its R15 read value
//   wordAlign()       - forces an address onto a word boundary
package arm_fetch_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] R15_OFFSET       = 32'd8;

  // Branch targets come straight from the ALU, so the low two bits are
  // meaningless for an instruction fetch and are simply cleared.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/arm_fetch_fifo.sv
// Prefetch queue for the fetch stage: a DEPTH-entry circular buffer of
// fetch_entry_t. A flush empties the queue and resets both pointers, and it
// overrides any push or pop in the same cycle.
//
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   push_i        - write push_data_i at the tail (ignored when full unless popping)
//   push_data_i   - entry to enqueue
//   pop_i         - drop the head entry (ignored when empty)
//   flush_i       - discard all entries
//   head_o        - current head entry (only meaningful when !empty_o)
//   full_o        - count_o == DEPTH
//   empty_o       - count_o == 0
//   count_o       - number of valid entries, 0..DEPTH
module arm_fetch_fifo
  import arm_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // A push into a full queue is only legal when the head leaves in the same
  // cycle; a pop from an empty queue has nothing to remove.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  // Pointers wrap naturally because DEPTH is a power of two. Simultaneous
  // push and pop leave the count unchanged.
  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (flush_i) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (doPush && !flush_i) begin
      mem_q[wrPtr_q] <= push_data_i;
    end
  end

  overflowCheck: assert property (@(posedge clk) disable iff (reset)
    push_i |-> (!full_o || pop_i || flush_i));

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction-fetch stage of the ARM core. Owns the fetch PC, issues one
// word read at a time to instruction memory, buffers returned words in a
// prefetch queue and hands them to decode over a valid/ready handshake.
// A redirect (PCSrc) flushes the queue and squashes any in-flight response.
//
// Ports:
//   clk, reset       - clock and synchronous active-high reset
//   imem_req         - one-cycle request pulse, address accepted that cycle
//   imem_addr        - word-aligned request address (the fetch PC)
//   imem_rvalid      - response valid for the single outstanding request
//   imem_rdata       - response instruction word
//   redirect         - taken branch or write to R15
//   redirect_target  - new PC; low two bits ignored
//   instr_valid      - queue head holds an instruction
//   instr_ready      - decode accepts the head this cycle
//   Instr            - head instruction word
//   instr_pc         - address of the head instruction
//   pc_plus8         - instr_pc + 8, the R15 read value
module arm_fetch_unit
  import arm_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] Instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetchPc_q, fetchPc_d;
  logic [31:0]      reqPc_q, reqPc_d;
  logic             outstanding_q, outstanding_d;
  logic             drop_q, drop_d;

  fetch_entry_t     pushEntry, headEntry;
  logic             fifoFull, fifoEmpty;
  logic [CNT_W-1:0] fifoCount;
  logic             issue, rspTaken, rspKeep, pushEn, popEn;

  // A request only goes out when nothing is in flight and the queue still
  // has room for its response, so the queue can never overflow.
  assign issue = !reset && !redirect && !outstanding_q
                 && (fifoCount < CNT_W'(DEPTH));

  // Responses without an outstanding request are ignored. A response is
  // kept only if it was not squashed by an earlier or simultaneous redirect.
  assign rspTaken = imem_rvalid && outstanding_q;
  assign rspKeep  = rspTaken && !drop_q && !redirect;
  assign popEn    = !fifoEmpty && instr_ready && !redirect;
  assign pushEn   = rspKeep && (!fifoFull || popEn);

  assign pushEntry.instr = imem_rdata;
  assign pushEntry.pc    = reqPc_q;

  arm_fetch_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (pushEn),
    .push_data_i(pushEntry),
    .pop_i      (popEn),
    .flush_i    (redirect),
    .head_o     (headEntry),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  assign imem_req    = issue;
  assign imem_addr   = fetchPc_q;
  assign instr_valid = !fifoEmpty;
  assign Instr       = fifoEmpty ? '0 : headEntry.instr;
  assign instr_pc    = fetchPc_head();
  assign pc_plus8    = instr_pc + R15_OFFSET;

  function automatic logic [31:0] fetchPc_head();
    return fifoEmpty ? '0 : headEntry.pc;
  endfunction

  // Redirect outranks issue. If a request is still in flight when the
  // redirect arrives, its response must be thrown away later (drop); if it
  // returns in the redirect cycle itself it is discarded right away. A
  // repeated redirect while drop is set keeps drop set, because the
  // squashed response has still not come back.
  always_comb begin
    fetchPc_d     = fetchPc_q;
    reqPc_d       = reqPc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (rspTaken) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
    end
    if (redirect) begin
      fetchPc_d = wordAlign(redirect_target);
      drop_d    = outstanding_q && !imem_rvalid;
    end else if (issue) begin
      reqPc_d       = fetchPc_q;
      fetchPc_d     = fetchPc_q + PC_INC;
      outstanding_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q     <= RESET_PC;
      reqPc_q       <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      reqPc_q       <= reqPc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  spuriousResponse: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> outstanding_q);

endmodule
